// File: rtl/m00_axi_read_arbiter_be_512x64_pkg.sv
// ==========================================================================
// m00_axi_read_arbiter_be_512x64_pkg: shared types/constants for the M00 read arbiter.  Rev 1.0
// ==========================================================================
`default_nettype none

package m00_axi_read_arbiter_be_512x64_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } m00_axi_arbiter_state_t;

  localparam logic [2:0] M00_AXI4_BE_ARSIZE       = 3'd6;
  localparam logic [1:0] M00_AXI4_BE_ARBURST_INCR = 2'b01;
  localparam logic [3:0] M00_AXI4_BE_ARCACHE      = 4'b0011;

endpackage

`default_nettype wire

// File: rtl/m00_axi_read_arbiter_be_512x64_if.sv
// ==========================================================================
// m00_axi_read_arbiter_be_512x64_if: requester-side and back-end AXI read interfaces.  Rev 1.0
// ==========================================================================
`default_nettype none

interface m00_axi_rd_req_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req_arvalid;
  logic [NUM_REQ-1:0][63:0] req_araddr;
  logic [NUM_REQ-1:0][7:0]  req_arlen;
  logic [NUM_REQ-1:0]       req_arready;
  logic [NUM_REQ-1:0]       req_rvalid;
  logic [511:0]             req_rdata;
  logic                     req_rlast;
  logic [1:0]               req_rresp;
  logic [NUM_REQ-1:0]       req_rready;

  modport master (
    output req_arvalid, req_araddr, req_arlen, req_rready,
    input  req_arready, req_rvalid, req_rdata, req_rlast, req_rresp
  );
  modport slave (
    input  req_arvalid, req_araddr, req_arlen, req_rready,
    output req_arready, req_rvalid, req_rdata, req_rlast, req_rresp
  );
endinterface

interface m00_axi_be_rd_if #(
  parameter int ID_W = 4
);
  logic            m_axi_arvalid;
  logic [63:0]     m_axi_araddr;
  logic [7:0]      m_axi_arlen;
  logic [ID_W-1:0] m_axi_arid;
  logic [2:0]      m_axi_arsize;
  logic [1:0]      m_axi_arburst;
  logic [3:0]      m_axi_arcache;
  logic            m_axi_arready;
  logic            m_axi_rvalid;
  logic [511:0]    m_axi_rdata;
  logic [ID_W-1:0] m_axi_rid;
  logic            m_axi_rlast;
  logic [1:0]      m_axi_rresp;
  logic            m_axi_rready;

  modport master (
    output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arid,
           m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_rready,
    input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rid,
           m_axi_rlast, m_axi_rresp
  );
  modport slave (
    input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arid,
           m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_rready,
    output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rid,
           m_axi_rlast, m_axi_rresp
  );
endinterface

`default_nettype wire

// File: rtl/m00_axi_read_arbiter_be_512x64_round_robin_pick.sv
// ==========================================================================
// round_robin_pick: rotating-priority one-hot picker starting after i_last_grant.  Rev 1.0
// ==========================================================================
`default_nettype none

module round_robin_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  wire logic [N-1:0]     i_req,
  input  wire logic [IDX_W-1:0] i_last_grant,
  output logic      [N-1:0]     o_grant,
  output logic                  o_valid
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_masked;
  logic [N-1:0] w_pool;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (i > int'(i_last_grant));
    end
  end

  // Requests above the last winner take priority; otherwise wrap to the bottom.
  assign w_masked = i_req & w_mask;
  assign w_pool   = (|w_masked) ? w_masked : i_req;
  assign o_grant  = w_pool & ((~w_pool) + N'(1));
  assign o_valid  = |i_req;

endmodule

`default_nettype wire

// File: rtl/m00_axi_read_arbiter_be_512x64.sv
// ==========================================================================
// m00_axi_read_arbiter_be_512x64: round-robin AR arbiter with RID-steered R return.  Rev 1.0
// ==========================================================================
`default_nettype none

module m00_axi_read_arbiter_be_512x64
  import m00_axi_read_arbiter_be_512x64_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int ID_W            = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  wire logic         ap_clk,
  input  wire logic         aresetn,
  m00_axi_rd_req_if.slave   req,
  m00_axi_be_rd_if.master   m_axi,
  output logic              rid_error
);

  localparam int               IDX_W   = $clog2(NUM_REQ);
  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  m00_axi_arbiter_state_t r_state;
  m00_axi_arbiter_state_t w_state_nxt;

  logic [IDX_W-1:0]   r_last_grant;
  logic [63:0]        r_araddr;
  logic [7:0]         r_arlen;
  logic [ID_W-1:0]    r_arid;
  logic [CNT_W-1:0]   r_cnt [NUM_REQ];
  logic               r_rid_error;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic [NUM_REQ-1:0] w_inc;
  logic [NUM_REQ-1:0] w_dec;
  logic [NUM_REQ-1:0] w_req_rvalid;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_gnt_vld;
  logic               w_grant;
  logic               w_ar_hs;
  logic               w_rid_ok;
  logic               w_rready;
  logic               w_r_hs;
  logic               w_cnt_err;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = req.req_arvalid[i] & (r_cnt[i] < MAX_CNT);
    end
  end

  round_robin_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req        (w_elig),
    .i_last_grant (r_last_grant),
    .o_grant      (w_gnt_oh),
    .o_valid      (w_gnt_vld)
  );

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_oh[i]) w_gnt_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge ap_clk or negedge aresetn) begin
    if (!aresetn) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_ar_hs     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_vld) begin
          w_grant     = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (m_axi.m_axi_arready) begin
          w_ar_hs     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge aresetn) begin
    if (!aresetn) begin
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_arid       <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (w_grant) begin
      r_araddr     <= req.req_araddr[w_gnt_idx];
      r_arlen      <= req.req_arlen[w_gnt_idx];
      r_arid       <= ID_W'(w_gnt_idx);
      r_last_grant <= w_gnt_idx;
    end
  end

  assign req.req_arready     = w_grant ? w_gnt_oh : '0;
  assign m_axi.m_axi_arvalid = (r_state == ISSUE);
  assign m_axi.m_axi_araddr  = r_araddr;
  assign m_axi.m_axi_arlen   = r_arlen;
  assign m_axi.m_axi_arid    = r_arid;
  assign m_axi.m_axi_arsize  = M00_AXI4_BE_ARSIZE;
  assign m_axi.m_axi_arburst = M00_AXI4_BE_ARBURST_INCR;
  assign m_axi.m_axi_arcache = M00_AXI4_BE_ARCACHE;

  // Out-of-range RIDs keep the default ready=1 so the stray beat is swallowed.
  always_comb begin
    w_rid_ok     = 1'b0;
    w_rready     = 1'b1;
    w_req_rvalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (m_axi.m_axi_rid == ID_W'(i)) begin
        w_rid_ok        = 1'b1;
        w_rready        = req.req_rready[i];
        w_req_rvalid[i] = m_axi.m_axi_rvalid;
      end
    end
  end

  assign w_r_hs             = m_axi.m_axi_rvalid & w_rready;
  assign m_axi.m_axi_rready = w_rready;
  assign req.req_rvalid     = w_req_rvalid;
  assign req.req_rdata      = m_axi.m_axi_rdata;
  assign req.req_rlast      = m_axi.m_axi_rlast;
  assign req.req_rresp      = m_axi.m_axi_rresp;

  always_comb begin
    w_cnt_err = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_inc[i] = w_ar_hs & (r_arid == ID_W'(i));
      w_dec[i] = w_r_hs & m_axi.m_axi_rlast & w_req_rvalid[i];
      if (w_dec[i] && (r_cnt[i] == '0)) w_cnt_err = 1'b1;
    end
  end

  // Coincident issue and completion on one requester cancel out.
  always_ff @(posedge ap_clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_inc[i] && !w_dec[i] && (r_cnt[i] != MAX_CNT))
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0))
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ap_clk or negedge aresetn) begin
    if (!aresetn)
      r_rid_error <= 1'b0;
    else if ((m_axi.m_axi_rvalid && !w_rid_ok) || w_cnt_err)
      r_rid_error <= 1'b1;
  end

  assign rid_error = r_rid_error;

endmodule

`default_nettype wire

// File: tb/tb_m00_axi_read_arbiter_be_512x64.sv
// ==========================================================================
// tb_m00_axi_read_arbiter_be_512x64: directed table, corner sequences and random model check.  Rev 1.0
// ==========================================================================
`default_nettype none

module tb_m00_axi_read_arbiter_be_512x64;

  localparam int NR   = 4;
  localparam int MAXO = 2;

  logic ap_clk;
  logic aresetn;
  logic rid_error;

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  m00_axi_rd_req_if #(.NUM_REQ(NR)) req_if ();
  m00_axi_be_rd_if  #(.ID_W(4))     axi_if ();

  m00_axi_read_arbiter_be_512x64 #(
    .NUM_REQ         (NR),
    .ID_W            (4),
    .MAX_OUTSTANDING (MAXO)
  ) u_dut (
    .ap_clk    (ap_clk),
    .aresetn   (aresetn),
    .req       (req_if),
    .m_axi     (axi_if),
    .rid_error (rid_error)
  );

  logic [3:0]       arv, rr, rid;
  logic [3:0][63:0] addr;
  logic [3:0][7:0]  len;
  logic             arr_in, rv, rl;
  logic [511:0]     rdata;
  logic [1:0]       rresp;

  assign req_if.req_arvalid   = arv;
  assign req_if.req_araddr    = addr;
  assign req_if.req_arlen     = len;
  assign req_if.req_rready    = rr;
  assign axi_if.m_axi_arready = arr_in;
  assign axi_if.m_axi_rvalid  = rv;
  assign axi_if.m_axi_rdata   = rdata;
  assign axi_if.m_axi_rid     = rid;
  assign axi_if.m_axi_rlast   = rl;
  assign axi_if.m_axi_rresp   = rresp;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] a, input logic ar, input logic v,
                     input logic [3:0] id, input logic l, input logic [3:0] r);
    @(negedge ap_clk);
    arv = a; arr_in = ar; rv = v; rid = id; rl = l; rr = r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    aresetn = 1'b0;
    arv = '0; arr_in = 1'b0; rv = 1'b0; rid = '0; rl = 1'b0; rr = '0;
    repeat (2) @(negedge ap_clk);
    aresetn = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  arv;
    logic        arr;
    logic        rv;
    logic [3:0]  rid;
    logic        rl;
    logic [3:0]  rr;
    logic [3:0]  e_arr;
    logic        e_av;
    logic [3:0]  e_id;
    logic [63:0] e_addr;
    logic [7:0]  e_len;
    logic [3:0]  e_rv;
    logic        e_rr;
  } vec_t;

  typedef struct {
    logic [3:0] id;
    int         len;
  } burst_t;

  vec_t   tbl [15];
  burst_t bq[$];

  // Reference model state
  bit         m_pend, m_err;
  int         m_last, m_id, m_beat;
  logic [63:0] m_addr;
  logic [7:0]  m_len;
  int         m_cnt [NR];
  bit [3:0]   hold;

  initial begin
    aresetn = 1'b0;
    arv = '0; arr_in = 1'b0; rv = 1'b0; rid = '0; rl = 1'b0; rr = '0;
    rdata = '0; rresp = '0;
    for (int i = 0; i < NR; i++) begin
      addr[i] = 64'h1000 + 64'h100 * i;
      len[i]  = 8'(3 + i);
    end

    // ---------------- reset values ----------------
    repeat (2) @(negedge ap_clk);
    #1;
    chk("rst.arvalid",   64'(axi_if.m_axi_arvalid), 0);
    chk("rst.arready",   64'(req_if.req_arready),   0);
    chk("rst.rid_error", 64'(rid_error),            0);
    chk("rst.araddr",    axi_if.m_axi_araddr,       0);
    chk("rst.arlen",     64'(axi_if.m_axi_arlen),   0);
    chk("rst.arid",      64'(axi_if.m_axi_arid),    0);
    chk("rst.arsize",    64'(axi_if.m_axi_arsize),  6);
    chk("rst.arburst",   64'(axi_if.m_axi_arburst), 1);
    chk("rst.arcache",   64'(axi_if.m_axi_arcache), 3);
    @(negedge ap_clk);
    aresetn = 1'b1;

    // ---------------- single request + round robin table ----------------
    tbl[0]  = '{4'b0001,1,0,0,0,4'hF, 4'b0001,0,0,64'h0,   8'd0,4'b0000,1};
    tbl[1]  = '{4'b0000,1,0,0,0,4'hF, 4'b0000,1,0,64'h1000,8'd3,4'b0000,1};
    tbl[2]  = '{4'b0000,1,1,0,0,4'hF, 4'b0000,0,0,64'h0,   8'd0,4'b0001,1};
    tbl[3]  = '{4'b0000,1,1,0,0,4'hF, 4'b0000,0,0,64'h0,   8'd0,4'b0001,1};
    tbl[4]  = '{4'b0000,1,1,0,0,4'hF, 4'b0000,0,0,64'h0,   8'd0,4'b0001,1};
    tbl[5]  = '{4'b0000,1,1,0,1,4'hF, 4'b0000,0,0,64'h0,   8'd0,4'b0001,1};
    tbl[6]  = '{4'b1111,1,0,0,0,4'hF, 4'b0010,0,0,64'h0,   8'd0,4'b0000,1};
    tbl[7]  = '{4'b1101,1,0,0,0,4'hF, 4'b0000,1,1,64'h1100,8'd4,4'b0000,1};
    tbl[8]  = '{4'b1101,1,0,0,0,4'hF, 4'b0100,0,0,64'h0,   8'd0,4'b0000,1};
    tbl[9]  = '{4'b1001,1,0,0,0,4'hF, 4'b0000,1,2,64'h1200,8'd5,4'b0000,1};
    tbl[10] = '{4'b1001,1,0,0,0,4'hF, 4'b1000,0,0,64'h0,   8'd0,4'b0000,1};
    tbl[11] = '{4'b0001,1,0,0,0,4'hF, 4'b0000,1,3,64'h1300,8'd6,4'b0000,1};
    tbl[12] = '{4'b0001,1,0,0,0,4'hF, 4'b0001,0,0,64'h0,   8'd0,4'b0000,1};
    tbl[13] = '{4'b0000,1,0,0,0,4'hF, 4'b0000,1,0,64'h1000,8'd3,4'b0000,1};
    tbl[14] = '{4'b0000,1,1,2,0,4'b1011, 4'b0000,0,0,64'h0,8'd0,4'b0100,0};

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].arv, tbl[i].arr, tbl[i].rv, tbl[i].rid, tbl[i].rl, tbl[i].rr);
      chk($sformatf("t%0d.req_arready", i), 64'(req_if.req_arready), 64'(tbl[i].e_arr));
      chk($sformatf("t%0d.arvalid", i), 64'(axi_if.m_axi_arvalid), 64'(tbl[i].e_av));
      if (tbl[i].e_av) begin
        chk($sformatf("t%0d.arid", i),   64'(axi_if.m_axi_arid),  64'(tbl[i].e_id));
        chk($sformatf("t%0d.araddr", i), axi_if.m_axi_araddr,     tbl[i].e_addr);
        chk($sformatf("t%0d.arlen", i),  64'(axi_if.m_axi_arlen), 64'(tbl[i].e_len));
      end
      chk($sformatf("t%0d.req_rvalid", i), 64'(req_if.req_rvalid), 64'(tbl[i].e_rv));
      chk($sformatf("t%0d.rready", i), 64'(axi_if.m_axi_rready), 64'(tbl[i].e_rr));
    end

    // ---------------- AR backpressure ----------------
    do_reset();
    cyc(4'b0100, 0, 0, 0, 0, 4'hF);
    chk("bp.grant", 64'(req_if.req_arready), 64'b0100);
    for (int k = 0; k < 5; k++) begin
      cyc(4'b0001, 0, 0, 0, 0, 4'hF);
      chk($sformatf("bp%0d.arvalid", k), 64'(axi_if.m_axi_arvalid), 1);
      chk($sformatf("bp%0d.araddr", k),  axi_if.m_axi_araddr, 64'h1200);
      chk($sformatf("bp%0d.arid", k),    64'(axi_if.m_axi_arid), 2);
      chk($sformatf("bp%0d.arlen", k),   64'(axi_if.m_axi_arlen), 5);
      chk($sformatf("bp%0d.noarready", k), 64'(req_if.req_arready), 0);
    end
    cyc(4'b0001, 1, 0, 0, 0, 4'hF);
    chk("bp.hs_arvalid", 64'(axi_if.m_axi_arvalid), 1);
    cyc(4'b0001, 1, 0, 0, 0, 4'hF);
    chk("bp.idle_arvalid", 64'(axi_if.m_axi_arvalid), 0);
    chk("bp.next_grant", 64'(req_if.req_arready), 64'b0001);

    // ---------------- outstanding cap (MAX_OUTSTANDING=2) ----------------
    do_reset();
    cyc(4'b0010, 1, 0, 0, 0, 4'hF); chk("cap.g1", 64'(req_if.req_arready), 64'b0010);
    cyc(4'b0000, 1, 0, 0, 0, 4'hF);
    cyc(4'b0010, 1, 0, 0, 0, 4'hF); chk("cap.g2", 64'(req_if.req_arready), 64'b0010);
    cyc(4'b0000, 1, 0, 0, 0, 4'hF);
    cyc(4'b0110, 1, 0, 0, 0, 4'hF); chk("cap.skip1a", 64'(req_if.req_arready), 64'b0100);
    cyc(4'b0010, 1, 0, 0, 0, 4'hF); chk("cap.issue2", 64'(axi_if.m_axi_arid), 2);
    cyc(4'b0110, 1, 0, 0, 0, 4'hF); chk("cap.skip1b", 64'(req_if.req_arready), 64'b0100);
    cyc(4'b0010, 1, 0, 0, 0, 4'hF);
    cyc(4'b0110, 1, 1, 1, 1, 4'hF);
    chk("cap.allfull", 64'(req_if.req_arready), 0);
    chk("cap.rvalid1", 64'(req_if.req_rvalid), 64'b0010);
    cyc(4'b0110, 1, 0, 0, 0, 4'hF); chk("cap.reopen", 64'(req_if.req_arready), 64'b0010);

    // ---------------- simultaneous inc/dec ----------------
    do_reset();
    cyc(4'b0001, 1, 0, 0, 0, 4'hF); chk("sim.g1", 64'(req_if.req_arready), 64'b0001);
    cyc(4'b0000, 1, 0, 0, 0, 4'hF);
    cyc(4'b0001, 1, 0, 0, 0, 4'hF); chk("sim.g2", 64'(req_if.req_arready), 64'b0001);
    cyc(4'b0000, 1, 1, 0, 1, 4'hF); chk("sim.both_av", 64'(axi_if.m_axi_arvalid), 1);
    cyc(4'b0001, 1, 0, 0, 0, 4'hF); chk("sim.g3", 64'(req_if.req_arready), 64'b0001);
    cyc(4'b0000, 1, 0, 0, 0, 4'hF);
    cyc(4'b0001, 1, 0, 0, 0, 4'hF); chk("sim.capped", 64'(req_if.req_arready), 0);
    chk("sim.no_err", 64'(rid_error), 0);

    // ---------------- bad RID, async reset mid-ISSUE ----------------
    do_reset();
    cyc(4'b0001, 0, 0, 0, 0, 4'h0);
    cyc(4'b0000, 0, 1, 7, 1, 4'h0);
    chk("bad.rready", 64'(axi_if.m_axi_rready), 1);
    chk("bad.rvalid", 64'(req_if.req_rvalid), 0);
    chk("bad.err_pre", 64'(rid_error), 0);
    cyc(4'b0000, 0, 0, 0, 0, 4'h0);
    chk("bad.err", 64'(rid_error), 1);
    chk("bad.issue", 64'(axi_if.m_axi_arvalid), 1);
    #2 aresetn = 1'b0;
    #1;
    chk("arst.arvalid", 64'(axi_if.m_axi_arvalid), 0);
    chk("arst.rid_error", 64'(rid_error), 0);
    @(negedge ap_clk);
    aresetn = 1'b1;
    cyc(4'b0000, 0, 1, 0, 1, 4'hF); chk("late.err_pre", 64'(rid_error), 0);
    cyc(4'b0000, 0, 0, 0, 0, 4'hF); chk("late.err", 64'(rid_error), 1);

    // ---------------- randomized traffic vs reference model ----------------
    do_reset();
    m_pend = 0; m_err = 0; m_last = NR - 1; m_id = 0; m_beat = 0;
    m_addr = '0; m_len = '0; hold = '0;
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    bq.delete();

    for (int n = 0; n < 3000; n++) begin
      logic [3:0] e_arr, e_rv;
      logic       e_rr;
      int         pick, inc_id, dec_id;
      bit         do_inc, do_dec;

      @(negedge ap_clk);
      for (int i = 0; i < NR; i++) begin
        if (!hold[i] && $urandom_range(0, 2) == 0) begin
          hold[i] = 1'b1;
          addr[i] = {$urandom, $urandom};
          len[i]  = 8'($urandom_range(0, 7));
        end
      end
      arv    = hold;
      arr_in = ($urandom_range(0, 3) != 0);
      rr     = 4'($urandom);
      rdata  = {16{$urandom}};
      rresp  = 2'($urandom);
      if (n > 2500 && $urandom_range(0, 63) == 0) begin
        rv = 1'b1; rid = 4'($urandom_range(NR, 15)); rl = 1'($urandom);
      end else if (bq.size() > 0 && $urandom_range(0, 1) == 1) begin
        rv = 1'b1; rid = bq[0].id; rl = (m_beat == bq[0].len);
      end else begin
        rv = 1'b0; rid = 4'($urandom_range(0, NR - 1)); rl = 1'($urandom);
      end
      #1;

      e_arr = '0; pick = -1;
      if (!m_pend) begin
        for (int k = 1; k <= NR; k++) begin
          int idx;
          idx = (m_last + k) % NR;
          if (pick < 0 && arv[idx] && m_cnt[idx] < MAXO) pick = idx;
        end
        if (pick >= 0) e_arr[pick] = 1'b1;
      end
      e_rr = (rid < NR) ? rr[rid] : 1'b1;
      e_rv = (rv && rid < NR) ? 4'(1 << rid) : 4'b0000;

      chk("rnd.req_arready", 64'(req_if.req_arready), 64'(e_arr));
      chk("rnd.arvalid", 64'(axi_if.m_axi_arvalid), 64'(m_pend));
      if (m_pend) begin
        chk("rnd.araddr", axi_if.m_axi_araddr, m_addr);
        chk("rnd.arlen",  64'(axi_if.m_axi_arlen), 64'(m_len));
        chk("rnd.arid",   64'(axi_if.m_axi_arid), 64'(m_id));
      end
      chk("rnd.req_rvalid", 64'(req_if.req_rvalid), 64'(e_rv));
      chk("rnd.rready", 64'(axi_if.m_axi_rready), 64'(e_rr));
      chk("rnd.rid_error", 64'(rid_error), 64'(m_err));
      chk("rnd.rdata", 64'(req_if.req_rdata == rdata), 1);
      chk("rnd.rlast", 64'(req_if.req_rlast), 64'(rl));
      chk("rnd.rresp", 64'(req_if.req_rresp), 64'(rresp));

      do_inc = 0; do_dec = 0; inc_id = 0; dec_id = 0;
      if (m_pend && arr_in) begin
        m_pend = 0; do_inc = 1; inc_id = m_id;
        bq.push_back('{4'(m_id), int'(m_len)});
      end
      if (pick >= 0) begin
        m_pend = 1; m_id = pick; m_addr = addr[pick]; m_len = len[pick];
        m_last = pick; hold[pick] = 1'b0;
      end
      if (rv && e_rr) begin
        if (rid >= NR) begin
          m_err = 1;
        end else begin
          if (bq.size() > 0 && rid == bq[0].id) begin
            if (rl) begin m_beat = 0; void'(bq.pop_front()); end
            else m_beat++;
          end
          if (rl) begin do_dec = 1; dec_id = int'(rid); end
        end
      end
      if (do_inc && do_dec && inc_id == dec_id) begin
        if (m_cnt[dec_id] == 0) m_err = 1;
      end else begin
        if (do_inc && m_cnt[inc_id] < MAXO) m_cnt[inc_id]++;
        if (do_dec) begin
          if (m_cnt[dec_id] == 0) m_err = 1;
          else m_cnt[dec_id]--;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/m00_axi_read_arbiter_be_512x64.md
# m00_axi_read_arbiter_be_512x64

Round-robin read-channel arbiter that shares the single M00 back-end AXI4 read port (512-bit data, 64-bit address) between `NUM_REQ` engine requesters. It sits directly upstream of the M00 back-end register slice. AR requests are granted one at a time and stamped with the requester index as ARID. R beats are steered back to the owning requester by RID, and per-requester outstanding-burst counts are capped.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `ID_W`, 4: ARID/RID width; must satisfy `2**ID_W >= NUM_REQ`.
- `MAX_OUTSTANDING`, 8: maximum accepted-but-incomplete bursts per requester, 1..255.
- `ap_clk`  in  1  single clock.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `req_arvalid`  in  NUM_REQ  per-requester read request valid.
- `req_araddr`  in  NUM_REQ×64  per-requester byte address.
- `req_arlen`  in  NUM_REQ×8  per-requester AXI burst length (beats−1).
- `req_arready`  out  NUM_REQ  request accepted (one-hot, single cycle).
- `req_rvalid`  out  NUM_REQ  R beat valid for requester i.
- `req_rdata`  out  512  shared R data, broadcast to all requesters.
- `req_rlast`  out  1  shared R last.
- `req_rresp`  out  2  shared R response.
- `req_rready`  in  NUM_REQ  per-requester R ready.
- `m_axi_arvalid`, `m_axi_araddr`[64], `m_axi_arlen`[8], `m_axi_arid`[ID_W], `m_axi_arsize`[3], `m_axi_arburst`[2], `m_axi_arcache`[4]  out: AR channel toward the register slice.
- `m_axi_arready`  in  1: AR channel ready from the register slice.
- `m_axi_rvalid`  in  1, `m_axi_rdata`  in  512, `m_axi_rid`  in  ID_W, `m_axi_rlast`  in  1, `m_axi_rresp`  in  2: R channel from the register slice.
- `m_axi_rready`  out  1: R channel ready toward the register slice.
- `rid_error`  out  1: sticky flag, set when a beat arrives with out-of-range RID.

## Operation
- The FSM has two states, `IDLE` and `ISSUE`.
- In `IDLE`, the eligible set is `req_arvalid[i] & (outstanding[i] < MAX_OUTSTANDING)`.
  - Pick the first eligible index searching from `last_grant+1` with wrap.
  - Register its addr and len into the AR holding register.
  - Pulse `req_arready[i]` in the same cycle, set `last_grant = i`, and go to `ISSUE`.
- In `ISSUE`, hold `m_axi_arvalid` high with stable fields until `m_axi_arready`. On that handshake:
  - increment `outstanding[arid]`;
  - return to `IDLE`.
- Fixed AR fields: `arsize=3'd6` (64 B), `arburst=2'b01` (INCR), `arcache=4'b0011`, `arid=grant index`.
- R steering (combinational):
  - `req_rvalid[i] = m_axi_rvalid & (m_axi_rid == i)`.
  - `m_axi_rready = req_rready[m_axi_rid]` when RID < NUM_REQ.
- When an R handshake carries `rlast`, decrement `outstanding[rid]`.
- If an AR handshake and an rlast handshake hit the same counter in the same cycle, the counter is unchanged.
- For RID ≥ NUM_REQ:
  - `m_axi_rready=1` and the beat is dropped;
  - no `req_rvalid` asserts;
  - `rid_error` sets and stays set until reset.
- Counters saturate defensively: no increment at MAX and no decrement at 0. An rlast arriving at count 0 also sets `rid_error`.
- Reset mid-operation:
  - all counters clear and the FSM returns to `IDLE`;
  - any pending AR is discarded;
  - R beats still in flight after reset are treated per the RID rules (counter at 0 ⇒ `rid_error`).

## Timing
- Reset values:
  - `m_axi_arvalid=0`, `req_arready=0`, `rid_error=0`;
  - AR fields = 0 except the fixed constants;
  - `last_grant=NUM_REQ-1`, so requester 0 wins first.
- AR latency: `req_arready` in cycle N, `m_axi_arvalid` from cycle N+1. Best-case throughput is one AR every 2 cycles.
- No grant is made while in `ISSUE`. The pointer advances only on grant.
- R path has zero latency (pure combinational). `req_rdata`, `req_rlast` and `req_rresp` pass through unregistered.
- A requester must hold `req_arvalid`/`req_araddr`/`req_arlen` until it sees `req_arready`.

## Structure
- Shared package carries:
  - the `m00_axi_arbiter_state_t` enum (`IDLE`, `ISSUE`);
  - constants `M00_AXI4_BE_ARSIZE=3'd6`, `M00_AXI4_BE_ARBURST_INCR=2'b01`, `M00_AXI4_BE_ARCACHE=4'b0011`.
- One natural sub-module, `round_robin_pick`: a combinational mask-and-priority-encode over `NUM_REQ` bits, given `last_grant`, returning a one-hot grant plus a valid flag.
- Outstanding counters are a `NUM_REQ`-entry array, each `$clog2(MAX_OUTSTANDING+1)` bits wide.

## Test plan
- **Reset then single request.** Drive req 0 with addr `0x1000`, len 3, and `m_axi_arready=1`.
  - Expect `req_arready[0]` at cycle 1 and `m_axi_arvalid` at cycle 2 with `arid=0`, `araddr=0x1000`, `arlen=3`, `arsize=6`.
  - Return 4 beats with rid 0 → `req_rvalid[0]` ×4 with `rlast` on beat 4; outstanding[0] returns to 0.
- **Round robin fairness.** Hold all 4 requests continuously → grant order is 0,1,2,3,0,1.
- **Backpressure.** Hold `m_axi_arready=0` for 5 cycles.
  - Expect the AR fields stable throughout and no further `req_arready`.
  - Release → handshake, FSM back to `IDLE`.
- **Outstanding cap.** Set `MAX_OUTSTANDING=2`; req 1 issues 2 bursts with no R returned.
  - Expect no third grant to req 1 while req 2 is still granted.
  - One rlast to rid 1 → req 1 becomes eligible again.
- **Simultaneous inc/dec.** In the same cycle, an AR handshake for req 0 and rlast for rid 0 with outstanding[0]=1 → outstanding[0] stays 1.
- **Bad RID and reset.** A beat with rid=7 (NUM_REQ=4) → `m_axi_rready=1`, no `req_rvalid`, `rid_error=1`. Assert `aresetn=0` mid-`ISSUE` → `m_axi_arvalid=0` immediately (asynchronously) and `rid_error=0`.
